// File: rtl/mux_pkg.sv
// Shared types for the 4-channel round-robin arbiter and its datapath mux.
package mux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0]        sel_t;
    typedef logic [NUM_CH-1:0] onehot_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic sel_t onehot_to_idx(input onehot_t oh);
        sel_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = idx | sel_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Four-input word multiplexer; the arbiter drives its select.
module mux_4_to_1 import mux_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [WIDTH-1:0] i_data3,
    input  sel_t             i_sel,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = '0;
        unique case (i_sel)
            2'd0: o_data = i_data0;
            2'd1: o_data = i_data1;
            2'd2: o_data = i_data2;
            2'd3: o_data = i_data3;
        endcase
    end

endmodule

// File: rtl/rr_grant_4.sv
// Rotating-priority selector: the channel after last_grant is searched first.
module rr_grant_4 import mux_pkg::*; (
    input  onehot_t req,
    input  sel_t    last_grant,
    output onehot_t grant,
    output sel_t    gidx,
    output logic    any
);

    sel_t idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = last_grant + sel_t'(k);
            if (req[idx] && !found) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gidx = onehot_to_idx(grant);
    assign any  = |req;

endmodule

// File: rtl/rr_arb_4_to_1.sv
// Round-robin arbiter feeding a one-deep registered valid/ready output stage.
module rr_arb_4_to_1 import mux_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_valid,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [WIDTH-1:0] i_data3,
    output logic [3:0]       o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_sel,
    input  logic             i_ready
);

    state_t           state_q;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q;
    sel_t             last_q;

    onehot_t grant;
    sel_t    gidx;
    logic    any;
    logic    room;
    logic    load;

    rr_grant_4 u_grant (
        .req        (i_valid),
        .last_grant (last_q),
        .grant      (grant),
        .gidx       (gidx),
        .any        (any)
    );

    mux_4_to_1 #(.WIDTH(WIDTH)) u_mux (
        .i_data0 (i_data0),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_data3 (i_data3),
        .i_sel   (gidx),
        .o_data  (data_d)
    );

    // Room depends only on state and i_ready, never on o_ready itself.
    assign room    = (state_q == EMPTY) || i_ready;
    assign load    = room && any;
    assign o_ready = grant & {NUM_CH{room}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= 2'd3;
        end else if (load) begin
            state_q <= FULL;
            data_q  <= data_d;
            sel_q   <= gidx;
            last_q  <= gidx;
        end else if (state_q == FULL && i_ready) begin
            state_q <= EMPTY;
        end
    end

    assign o_valid = (state_q == FULL);
    assign o_data  = data_q;
    assign o_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_4_to_1.sv
// Scoreboard bench for rr_arb_4_to_1: directed vectors plus a randomised soak.
module tb_rr_arb_4_to_1;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   o_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic [1:0]   o_sel;
    logic         i_ready;

    int   checks   = 0;
    int   failures = 0;
    ent_t sb[$];

    logic       rand_en = 1'b0;
    logic [3:0] acc     = '0;
    logic [1:0] m_last;
    logic       m_full;
    int         waitc[4];
    int         seq = 0;

    rr_arb_4_to_1 #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .i_data0 (d0),
        .i_data1 (d1),
        .i_data2 (d2),
        .i_data3 (d3),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic [1:0] s);
        ent_t e;
        e.d = d;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] chdata(input int n);
        case (n)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Output monitor: pops on every output transfer.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", {30'd0, o_sel, o_data}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", o_data, e.d);
                    chk("sb_sel", o_sel, e.s);
                end
            end
        end
    end

    // Random-phase input monitor and independent arbitration model.
    initial begin
        logic [3:0] eg;
        logic [1:0] ei;
        logic       el;
        int         idx;
        forever begin
            @(negedge clk);
            if (rand_en && !rst) begin
                chk("multi_hot", $countones(o_ready) <= 1, 1);
                eg  = '0;
                ei  = '0;
                idx = m_last;
                for (int k = 0; k < 4; k++) begin
                    idx = (idx + 1) % 4;
                    if (eg == 0 && i_valid[idx]) begin
                        eg[idx] = 1'b1;
                        ei      = 2'(idx);
                    end
                end
                el = (!m_full || i_ready) && (i_valid != 0);
                chk("model_valid", o_valid, m_full);
                chk("model_ready", o_ready, el ? eg : 4'b0);
                acc = i_valid & o_ready;
                for (int n = 0; n < 4; n++) begin
                    if (acc[n]) push(chdata(n), 2'(n));
                end
                if (el) begin
                    for (int n = 0; n < 4; n++) begin
                        if (n == ei) begin
                            waitc[n] = 0;
                        end else if (i_valid[n]) begin
                            waitc[n]++;
                            chk("fair_wait", waitc[n] <= 3, 1);
                        end
                    end
                    m_last = ei;
                    m_full = 1'b1;
                end else if (m_full && i_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        m_last = 2'd3;
        m_full = 1'b0;

        // Reset state
        step();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sel", o_sel, 0);

        // All four valid: strict 0,1,2,3,0 rotation
        rst = 1'b0;
        i_valid = 4'b1111;
        d0 = 32'h10; d1 = 32'h11; d2 = 32'h12; d3 = 32'h13;
        i_ready = 1'b1;
        push(32'h10, 0); push(32'h11, 1); push(32'h12, 2);
        push(32'h13, 3); push(32'h10, 0);
        #1 chk("rr_first_ready", o_ready, 4'b0001);
        repeat (5) @(posedge clk);
        #1 i_valid = '0;

        // Drain with no new request
        step();
        chk("drain_valid", o_valid, 0);
        chk("drain_data", o_data, 32'h10);
        chk("drain_sel", o_sel, 0);

        // Single requester, then pointer after channel 2
        i_valid = 4'b0100;
        d2 = 32'hA5;
        push(32'hA5, 2);
        #1 chk("single_ready", o_ready, 4'b0100);
        step();
        i_valid = 4'b0101;
        d0 = 32'h5A;
        push(32'h5A, 0);
        #1 chk("after2_ready", o_ready, 4'b0001);
        step();
        i_valid = '0;

        // Stall holds the word and blocks all channels
        step();
        i_valid = 4'b0010;
        d1 = 32'h55;
        push(32'h55, 1);
        step();
        i_ready = 1'b0;
        i_valid = 4'b1111;
        d0 = 32'h10; d2 = 32'h12; d3 = 32'h13;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stall_ready", o_ready, 4'b0000);
            chk("stall_data", o_data, 32'h55);
            step();
        end
        i_ready = 1'b1;
        push(32'h12, 2);
        #1 chk("unstall_ready", o_ready, 4'b0100);
        step();
        i_valid = '0;
        step();

        // Asynchronous reset while holding a word
        i_ready = 1'b0;
        i_valid = 4'b0001;
        d0 = 32'h77;
        step();
        i_valid = '0;
        #1;
        chk("pre_rst_data", o_data, 32'h77);
        chk("pre_rst_valid", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data", o_data, 0);
        chk("arst_sel", o_sel, 0);
        step();
        rst = 1'b0;
        i_valid = 4'b1010;
        d1 = 32'h21; d3 = 32'h23;
        i_ready = 1'b1;
        push(32'h21, 1); push(32'h23, 3);
        #1 chk("post_rst_ready", o_ready, 4'b0010);
        step();
        #1 chk("post_rst_next", o_ready, 4'b1000);
        step();
        i_valid = '0;
        step();
        step();
        chk("directed_sb_empty", sb.size(), 0);

        // Randomised soak against the model
        rst = 1'b1;
        sb.delete();
        m_last = 2'd3;
        m_full = 1'b0;
        for (int n = 0; n < 4; n++) waitc[n] = 0;
        i_valid = '0;
        i_ready = 1'b0;
        #1 rst = 1'b0;
        rand_en = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            step();
            for (int n = 0; n < 4; n++) begin
                if (acc[n] || !i_valid[n]) begin
                    i_valid[n] = 1'($urandom_range(0, 1));
                    seq++;
                    case (n)
                        0: d0 = {4'h0, 28'(seq)};
                        1: d1 = {4'h1, 28'(seq)};
                        2: d2 = {4'h2, 28'(seq)};
                        default: d3 = {4'h3, 28'(seq)};
                    endcase
                end
            end
            i_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        i_valid = '0;
        i_ready = 1'b1;
        repeat (3) step();
        rand_en = 1'b0;
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
